ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes the raw byte stream of the PS/2 keyboard receiver (one scan-code-set-2 byte per `read_key` pulse) and turns it into ASCII key events for the CPU keyboard port. It tracks prefixes (E0/F0/E1), modifier state and caps lock, translates make codes to ASCII, and buffers characters in a small FIFO with a valid/ready read interface.

## Interface
- `FIFO_DEPTH`, 8: character FIFO entries; power of two, ≥2.
- `SYNC_STAGES`, 2: synchronizer flops on `scan_strobe`; ≥2.
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `scan_code` in 8: receiver byte (`decoded_key`); stable while `scan_strobe` is high.
- `scan_strobe` in 1: receiver `read_key`. Not clk-synchronous; high for about one PS/2 bit time.
- `key_data` out 8: FIFO head character.
- `key_valid` out 1: FIFO non-empty.
- `key_ready` in 1: consumer pops the head when `key_valid && key_ready`.
- `fifo_overflow` out 1: sticky; set on a dropped character; cleared only by `rst`.
- `mod_shift`, `mod_ctrl`, `caps_lock` out 1 each: live modifier state.

## Operation
- **Strobe input:** `scan_strobe` passes through `SYNC_STAGES` flops, then a rising-edge detector.
  - On the edge, `scan_code` is captured into `code_q`.
  - The sync chain and edge register keep sampling during `rst`. The edge pulse is gated by `rst`, so no spurious byte appears after reset release.
- **Parser states:** `S_BASE`, `S_EXT` (seen E0), `S_BRK` (seen F0), `S_EXT_BRK` (seen E0 F0), `S_SKIP`.
  - E0: BASE→EXT.
  - F0: BASE→BRK, EXT→EXT_BRK.
  - Any other byte completes the event and returns to BASE.
  - E1: load `skip_cnt` = 7 and go to SKIP. Each byte decrements `skip_cnt`; at 0, return to BASE. Pause never emits output.
  - 0x00, 0xAA, 0xFA, 0xEE, 0xFE, 0xFF: ignored in any non-SKIP state; force BASE.
- **Modifiers:**
  - 0x12/0x59 (L/R shift): make sets its own held bit, break clears it; `mod_shift` is the OR of both.
  - 0x14 and E0 14 (L/R ctrl): handled the same way, giving `mod_ctrl`.
  - 0x58 caps lock: toggles `caps_lock` on a make only when not already held, so typematic repeats do not toggle. Its break clears the held bit.
- **Translation** (make codes only; breaks emit nothing; US layout):
  - Letters give lowercase. Uppercase when `mod_shift ^ caps_lock`.
  - Digits and punctuation take their shifted symbols on `mod_shift` only.
  - Fixed codes: 0x29→0x20, 0x5A→0x0D, 0x66→0x08, 0x0D→0x09, 0x76→0x1B.
  - `mod_ctrl` with a letter gives `uppercase & 0x1F`.
  - Unmapped codes are dropped.
- **FIFO:**
  - A translated character is pushed into the FIFO.
  - Push when full without a simultaneous pop: the character is dropped and `fifo_overflow` is set.
  - Push and pop in the same cycle are always accepted, including when full.
  - Pop when empty is ignored.

## Timing
- **Reset values:**
  - `key_data`=0x00, `key_valid`=0, `fifo_overflow`=0, all modifiers 0.
  - Parser state S_BASE, `skip_cnt`=0, FIFO empty.
- **Latency:**
  - Edge pulse and `code_q` register on clk edge `SYNC_STAGES`+1 after `scan_strobe` rises.
  - Parser, modifiers and FIFO write update on the next edge.
  - `key_valid`/`key_data` are valid after edge `SYNC_STAGES`+3 (5 with defaults).
  - Modifier outputs are valid after edge `SYNC_STAGES`+2.
- **Throughput:** one byte per strobe. Strobes are ≥50 µs apart, so the parser is never back-pressured.
- **Read side:** `key_data` is registered and reflects the new head the cycle after a pop.
- **Reset mid-sequence** (e.g. after F0): the pending prefix is discarded. The next byte is parsed from BASE.

## Configuration
- `PS2_EXTENDED_KEYS_EN` defined: E0-prefixed makes translate as follows.
  - E0 75→0x80 (up), E0 72→0x81 (down), E0 6B→0x82 (left), E0 74→0x83 (right).
  - E0 4A→'/', E0 5A→0x0D.
- Undefined: E0 sequences are still parsed, and E0 14 still drives `mod_ctrl`. All other E0 makes emit nothing.

## Structure
- Package `ps2_pkg` holds:
  - The parser state enum.
  - Scan-code constants (`SC_E0`, `SC_F0`, `SC_E1`, `SC_LSHIFT`, `SC_RSHIFT`, `SC_CTRL`, `SC_CAPS`).
  - Special output codes (`KEY_UP`..`KEY_RIGHT`).
  - The translation function.
- One sub-module, `ps2_key_fifo`: a synchronous FIFO parameterized by `FIFO_DEPTH`, with a registered head and an overflow flag.

## Test plan
- Strobe 0x1C, then F0 1C → one entry 0x61 ('a'); `key_valid` rises exactly 5 clk after the strobe; the break emits nothing.
- 12, 1C, F0 1C, F0 12 → 0x41 ('A'); `mod_shift` is 1 between the 0x12 make and its break.
- 58, 58, F0 58, then 1C → `caps_lock`=1 (the repeat does not toggle); output 0x41. Same with shift held → 0x61.
- 14, 21 → 0x03. E1 14 77 E1 F0 14 F0 77, then 1C → only 0x61; `mod_ctrl` stays 0.
- Nine makes of 0x1C with `key_ready`=0 (depth 8) → 8 entries and `fifo_overflow`=1. Hold push+pop when full → no further overflow.
- E0 75 → 0x80 with `PS2_EXTENDED_KEYS_EN`, nothing without it. F0 then `rst`, then 1C → 0x61 emitted.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code-set-2 decoder: parser states,
// scan-code constants, special output codes and the make-code translator.
// Optional feature macro: PS2_EXTENDED_KEYS_EN (E0-prefixed arrow keys,
// keypad '/' and keypad Enter produce characters when defined).
package ps2_pkg;

   typedef enum logic [2:0] {
      S_BASE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_SKIP
   } parse_state_t;

   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_E1     = 8'hE1;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;

   localparam logic [7:0] KEY_UP    = 8'h80;
   localparam logic [7:0] KEY_DOWN  = 8'h81;
   localparam logic [7:0] KEY_LEFT  = 8'h82;
   localparam logic [7:0] KEY_RIGHT = 8'h83;

   // Bytes that follow E1 in the Pause sequence (14 77 E1 F0 14 F0 77).
   localparam logic [2:0] PAUSE_TAIL = 3'd7;

   typedef struct packed {
      logic       valid;
      logic [7:0] ch;
   } key_char_t;

   // Keyboard responses / error bytes that never belong to a key event.
   function automatic logic is_ignored(input logic [7:0] code);
      return code inside {8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF};
   endfunction

   // Translate one make code to ASCII (US layout) given the live modifiers.
   function automatic key_char_t translate_code(input logic [7:0] code,
                                                input logic       ext,
                                                input logic       shift,
                                                input logic       caps,
                                                input logic       ctrl);
      key_char_t   res;
      logic [7:0]  lower;
      logic [15:0] pair;    // {unshifted, shifted}
      logic        letter;
      logic        symbol;
      res    = '0;
      lower  = '0;
      pair   = '0;
      letter = 1'b0;
      symbol = 1'b0;
      if (ext) begin
`ifdef PS2_EXTENDED_KEYS_EN
         res.valid = 1'b1;
         case (code)
            8'h75:   res.ch = KEY_UP;
            8'h72:   res.ch = KEY_DOWN;
            8'h6B:   res.ch = KEY_LEFT;
            8'h74:   res.ch = KEY_RIGHT;
            8'h4A:   res.ch = 8'h2F;
            8'h5A:   res.ch = 8'h0D;
            default: res.valid = 1'b0;
         endcase
`else
         res.valid = 1'b0;
`endif
      end else begin
         letter = 1'b1;
         case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            default: letter = 1'b0;
         endcase
         symbol = 1'b1;
         case (code)
            8'h16: pair = "1!";  8'h1E: pair = "2@";  8'h26: pair = "3#";
            8'h25: pair = "4$";  8'h2E: pair = "5%";  8'h36: pair = "6^";
            8'h3D: pair = "7&";  8'h3E: pair = "8*";  8'h46: pair = "9(";
            8'h45: pair = "0)";  8'h0E: pair = "`~";  8'h4E: pair = "-_";
            8'h55: pair = "=+";  8'h54: pair = "[{";  8'h5B: pair = "]}";
            8'h5D: pair = {8'h5C, 8'h7C};
            8'h4C: pair = ";:";
            8'h52: pair = {8'h27, 8'h22};
            8'h41: pair = ",<";  8'h49: pair = ".>";  8'h4A: pair = "/?";
            8'h29: pair = {8'h20, 8'h20};
            8'h5A: pair = {8'h0D, 8'h0D};
            8'h66: pair = {8'h08, 8'h08};
            8'h0D: pair = {8'h09, 8'h09};
            8'h76: pair = {8'h1B, 8'h1B};
            default: symbol = 1'b0;
         endcase
         if (letter) begin
            res.valid = 1'b1;
            if (ctrl)
               res.ch = lower & 8'h1F;
            else if (shift ^ caps)
               res.ch = lower & 8'hDF;
            else
               res.ch = lower;
         end else if (symbol) begin
            res.valid = 1'b1;
            res.ch    = shift ? pair[7:0] : pair[15:8];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/ps2_key_fifo.sv
// Character FIFO with a registered head byte, registered non-empty flag and
// a sticky overflow flag. A push while full is accepted only when a pop
// happens in the same cycle.
module ps2_key_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] head,
   output logic       valid,
   output logic       overflow
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] rd_ptr_nxt;
   logic [AW:0]   count;
   logic [AW:0]   count_nxt;
   logic [AW:0]   remaining;
   logic          full;
   logic          push_ok;
   logic          pop_ok;

   // Accept/reject decisions and next-cycle occupancy.
   always_comb begin
      // NOTE: every always_comb output gets a value on every path; anything
      // left unassigned on some path would be inferred as a latch.
      full       = (count == (AW+1)'(DEPTH));
      pop_ok     = pop && (count != '0);
      push_ok    = push && (!full || pop_ok);
      rd_ptr_nxt = rd_ptr + AW'(pop_ok);
      remaining  = count - (AW+1)'(pop_ok);
      count_nxt  = remaining + (AW+1)'(push_ok);
   end

   // Storage array write port.
   // NOTE: the storage array has no reset; only pointers and flags need
   // one, and leaving it out lets the array map onto plain RAM cells.
   always_ff @(posedge clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy, registered head and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         head     <= 8'h00;
         valid    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr <= rd_ptr_nxt;
         count  <= count_nxt;
         valid  <= (count_nxt != '0);
         // Incoming byte becomes the head when nothing else is left ahead of it.
         if (push_ok && (remaining == '0))
            head <= push_data;
         else if (count_nxt != '0)
            head <= mem[rd_ptr_nxt];
         if (push && !push_ok)
            overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code-set-2 to ASCII key-event decoder. Synchronizes the
// receiver's read strobe, parses E0/F0/E1 prefixes, tracks shift, ctrl and
// caps lock, translates make codes and queues characters for the CPU.
// Optional feature macro: PS2_EXTENDED_KEYS_EN (see ps2_pkg).
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] scan_code,
   input  logic       scan_strobe,
   output logic [7:0] key_data,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       fifo_overflow,
   output logic       mod_shift,
   output logic       mod_ctrl,
   output logic       caps_lock
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   strobe_prev;
   logic                   byte_stb;
   logic [7:0]             code_q;

   parse_state_t state;
   logic [2:0]   skip_cnt;
   logic         lshift, rshift;
   logic         lctrl, rctrl;
   logic         caps_held;
   logic         push_q;
   logic [7:0]   push_char;

   logic         is_ext;
   logic         is_brk;
   key_char_t    xlat;

   // Strobe synchronizer and edge history, free-running through reset.
   // NOTE: these flops deliberately have no reset so they keep tracking the
   // asynchronous strobe while rst is high; the pulse below is what is gated.
   always_ff @(posedge clk) begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], scan_strobe};
      strobe_prev <= sync_q[SYNC_STAGES-1];
   end

   // Rising-edge pulse and capture of the receiver byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         byte_stb <= 1'b0;
         code_q   <= 8'h00;
      end else begin
         byte_stb <= sync_q[SYNC_STAGES-1] & ~strobe_prev;
         if (sync_q[SYNC_STAGES-1] & ~strobe_prev)
            code_q <= scan_code;
      end
   end

   // Prefix context and translation of the captured byte.
   always_comb begin
      is_ext = (state == S_EXT) || (state == S_EXT_BRK);
      is_brk = (state == S_BRK) || (state == S_EXT_BRK);
      xlat   = translate_code(code_q, is_ext, mod_shift, caps_lock, mod_ctrl);
   end

   // Prefix parser, modifier tracking and FIFO write request.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_BASE;
         skip_cnt  <= 3'd0;
         lshift    <= 1'b0;
         rshift    <= 1'b0;
         lctrl     <= 1'b0;
         rctrl     <= 1'b0;
         caps_held <= 1'b0;
         caps_lock <= 1'b0;
         push_q    <= 1'b0;
         push_char <= 8'h00;
      end else begin
         // NOTE: state registers use non-blocking assignments so every
         // decision in this block sees the values from before this edge.
         push_q <= 1'b0;
         if (byte_stb) begin
            if (state == S_SKIP) begin
               skip_cnt <= skip_cnt - 3'd1;
               if (skip_cnt == 3'd1)
                  state <= S_BASE;
            end else if (is_ignored(code_q)) begin
               state <= S_BASE;
            end else if (code_q == SC_E1) begin
               state    <= S_SKIP;
               skip_cnt <= PAUSE_TAIL;
            end else if ((code_q == SC_E0) && (state == S_BASE)) begin
               state <= S_EXT;
            end else if ((code_q == SC_F0) && (state == S_BASE)) begin
               state <= S_BRK;
            end else if ((code_q == SC_F0) && (state == S_EXT)) begin
               state <= S_EXT_BRK;
            end else begin
               // Any other byte completes the pending event.
               state <= S_BASE;
               if (!is_ext) begin
                  case (code_q)
                     SC_LSHIFT: lshift <= !is_brk;
                     SC_RSHIFT: rshift <= !is_brk;
                     SC_CTRL:   lctrl  <= !is_brk;
                     SC_CAPS: begin
                        if (is_brk) begin
                           caps_held <= 1'b0;
                        end else if (!caps_held) begin
                           caps_held <= 1'b1;
                           caps_lock <= ~caps_lock;
                        end
                     end
                     default: ;
                  endcase
               end else if (code_q == SC_CTRL) begin
                  rctrl <= !is_brk;
               end
               if (!is_brk && xlat.valid) begin
                  push_q    <= 1'b1;
                  push_char <= xlat.ch;
               end
            end
         end
      end
   end

   assign mod_shift = lshift | rshift;
   assign mod_ctrl  = lctrl | rctrl;

   ps2_key_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_q),
      .push_data (push_char),
      .pop       (key_valid && key_ready),
      .head      (key_data),
      .valid     (key_valid),
      .overflow  (fifo_overflow)
   );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed sequences followed
// by randomized key traffic, checked against a table-driven key model.
module tb_ps2_scancode_decoder;

   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] scan_code;
   logic       scan_strobe;
   logic [7:0] key_data;
   logic       key_valid;
   logic       key_ready;
   logic       fifo_overflow;
   logic       mod_shift;
   logic       mod_ctrl;
   logic       caps_lock;

   always #10 clk = ~clk;

   ps2_scancode_decoder #(
      .FIFO_DEPTH  (DEPTH),
      .SYNC_STAGES (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .scan_code     (scan_code),
      .scan_strobe   (scan_strobe),
      .key_data      (key_data),
      .key_valid     (key_valid),
      .key_ready     (key_ready),
      .fifo_overflow (fifo_overflow),
      .mod_shift     (mod_shift),
      .mod_ctrl      (mod_ctrl),
      .caps_lock     (caps_lock)
   );

   int compared   = 0;
   int mismatched = 0;

   // Key tables: letters in alphabetical order, symbols as parallel tables.
   byte unsigned letter_code [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                      8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                      8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   byte unsigned sym_code [21] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h45, 8'h0E, 8'h4E, 8'h55, 8'h54,
                                   8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};
   byte unsigned sym_plain [21] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                                    8'h38, 8'h39, 8'h30, 8'h60, 8'h2D, 8'h3D, 8'h5B,
                                    8'h5D, 8'h5C, 8'h3B, 8'h27, 8'h2C, 8'h2E, 8'h2F};
   byte unsigned sym_shift [21] = '{8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26,
                                    8'h2A, 8'h28, 8'h29, 8'h7E, 8'h5F, 8'h2B, 8'h7B,
                                    8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
   byte unsigned fix_code [5] = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
   byte unsigned fix_char [5] = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
   byte unsigned ext_code [6] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h4A, 8'h5A};
   byte unsigned ext_char [6] = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h2F, 8'h0D};

   // Model state: queued characters, held keys, pending prefixes.
   byte unsigned exp_q [$];
   bit m_sl, m_sr, m_cl, m_cr, m_caps_held, m_caps, m_ovf, m_ext, m_brk;
   int m_skip;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, obs, exp);
      end
   endtask

   function automatic int expect_char(input byte unsigned c, input bit ext);
      bit shift, ctrl;
      shift = m_sl | m_sr;
      ctrl  = m_cl | m_cr;
      if (ext) begin
`ifdef PS2_EXTENDED_KEYS_EN
         for (int i = 0; i < 6; i++)
            if (ext_code[i] == c) return int'(ext_char[i]);
`endif
         return -1;
      end
      for (int i = 0; i < 26; i++)
         if (letter_code[i] == c) begin
            if (ctrl) return (8'h41 + i) & 8'h1F;
            return (shift ^ m_caps) ? (8'h41 + i) : (8'h61 + i);
         end
      for (int i = 0; i < 21; i++)
         if (sym_code[i] == c) return shift ? int'(sym_shift[i]) : int'(sym_plain[i]);
      for (int i = 0; i < 5; i++)
         if (fix_code[i] == c) return int'(fix_char[i]);
      return -1;
   endfunction

   task automatic model_byte(input byte unsigned c);
      bit make;
      int ch;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (c inside {8'h00, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFF}) begin
         m_ext = 0; m_brk = 0;
         return;
      end
      if (c == 8'hE1) begin
         m_skip = 7; m_ext = 0; m_brk = 0;
         return;
      end
      if (c == 8'hE0 && !m_ext && !m_brk) begin
         m_ext = 1;
         return;
      end
      if (c == 8'hF0 && !m_brk) begin
         m_brk = 1;
         return;
      end
      make = !m_brk;
      ch   = make ? expect_char(c, m_ext) : -1;
      if (!m_ext) begin
         if (c == 8'h12) m_sl = make;
         if (c == 8'h59) m_sr = make;
         if (c == 8'h14) m_cl = make;
         if (c == 8'h58) begin
            if (!make) m_caps_held = 0;
            else if (!m_caps_held) begin
               m_caps_held = 1;
               m_caps = !m_caps;
            end
         end
      end else if (c == 8'h14) begin
         m_cr = make;
      end
      if (ch >= 0) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(byte'(ch));
         else m_ovf = 1;
      end
      m_ext = 0; m_brk = 0;
   endtask

   // mode 0: plain; 1: check key_valid latency; 2: pop exactly on the push edge.
   task automatic send_byte(input byte unsigned c, input int mode = 0);
      @(negedge clk);
      scan_code   = c;
      scan_strobe = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      if (mode == 1) chk("latency_edge4_valid", key_valid, 1'b0);
      if (mode == 2) begin
         chk("head_before_pushpop", key_data, exp_q[0]);
         void'(exp_q.pop_front());
         key_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      key_ready = 1'b0;
      if (mode == 1) chk("latency_edge5_valid", key_valid, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      scan_strobe = 1'b0;
      model_byte(c);
      repeat (8) @(posedge clk);
      #1;
      chk("mod_shift", mod_shift, m_sl | m_sr);
      chk("mod_ctrl", mod_ctrl, m_cl | m_cr);
      chk("caps_lock", caps_lock, m_caps);
   endtask

   task automatic drain();
      for (int n = 0; n < DEPTH + 4; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
         chk("key_valid_pending", key_valid, 1'b1);
         chk("key_data", key_data, exp_q[0]);
         void'(exp_q.pop_front());
         key_ready = 1'b1;
         @(posedge clk);
         #1;
         key_ready = 1'b0;
      end
      @(negedge clk);
      chk("empty_after_drain", key_valid, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      m_sl = 0; m_sr = 0; m_cl = 0; m_cr = 0;
      m_caps_held = 0; m_caps = 0; m_ovf = 0;
      m_ext = 0; m_brk = 0; m_skip = 0;
   endtask

   task automatic key_tap(input byte unsigned c);
      send_byte(c);
      send_byte(8'hF0);
      send_byte(c);
   endtask

   initial begin
      byte unsigned k;
      rst         = 1'b1;
      scan_code   = 8'h00;
      scan_strobe = 1'b0;
      key_ready   = 1'b0;
      do_reset();

      // Reset values.
      @(negedge clk);
      chk("rst_key_data", key_data, 8'h00);
      chk("rst_key_valid", key_valid, 1'b0);
      chk("rst_overflow", fifo_overflow, 1'b0);
      chk("rst_mod_shift", mod_shift, 1'b0);
      chk("rst_mod_ctrl", mod_ctrl, 1'b0);
      chk("rst_caps_lock", caps_lock, 1'b0);

      // Plain letter with latency check; the break emits nothing.
      send_byte(8'h1C, 1);
      send_byte(8'hF0);
      send_byte(8'h1C);
      drain();

      // Shifted letter.
      send_byte(8'h12);
      chk("shift_held", mod_shift, 1'b1);
      key_tap(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h12);
      chk("shift_released", mod_shift, 1'b0);
      drain();

      // Caps lock with typematic repeat, then shift cancelling caps.
      send_byte(8'h58);
      send_byte(8'h58);
      send_byte(8'hF0);
      send_byte(8'h58);
      chk("caps_after_repeat", caps_lock, 1'b1);
      key_tap(8'h1C);
      send_byte(8'h12);
      key_tap(8'h1C);
      send_byte(8'hF0);
      send_byte(8'h12);
      send_byte(8'h58);
      send_byte(8'hF0);
      send_byte(8'h58);
      drain();

      // Ctrl+C, then Pause sequence followed by a letter.
      send_byte(8'h14);
      key_tap(8'h21);
      send_byte(8'hF0);
      send_byte(8'h14);
      foreach (ext_code[i]) begin end
      send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
      send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
      chk("ctrl_after_pause", mod_ctrl, 1'b0);
      send_byte(8'h1C);
      drain();

      // Full FIFO with a simultaneous push and pop: accepted, no overflow.
      do_reset();
      repeat (DEPTH) send_byte(8'h1C);
      send_byte(8'h32, 2);
      chk("no_overflow_pushpop", fifo_overflow, 1'b0);
      drain();

      // Overflow on the ninth character.
      repeat (DEPTH + 1) send_byte(8'h1C);
      chk("overflow_set", fifo_overflow, 1'b1);
      chk("overflow_model", fifo_overflow, m_ovf);
      drain();
      chk("overflow_sticky", fifo_overflow, 1'b1);

      // Extended arrow key make and break.
      send_byte(8'hE0);
      send_byte(8'h75);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h75);
      drain();

      // Reset after a break prefix: next byte parsed from BASE.
      send_byte(8'hF0);
      do_reset();
      send_byte(8'h1C);
      drain();

      // Randomized key traffic.
      do_reset();
      for (int it = 0; it < 80; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: key_tap(letter_code[$urandom_range(0, 25)]);
            4: key_tap(sym_code[$urandom_range(0, 20)]);
            5: begin
               k = ($urandom_range(0, 1) != 0) ? 8'h12 : 8'h59;
               if ($urandom_range(0, 1) != 0) send_byte(8'hF0);
               send_byte(k);
            end
            6: begin
               if ($urandom_range(0, 1) != 0) send_byte(8'hF0);
               send_byte(8'h58);
            end
            7: begin
               if ($urandom_range(0, 1) != 0) send_byte(8'hE0);
               if ($urandom_range(0, 2) == 0) send_byte(8'hF0);
               send_byte(8'h14);
            end
            8: begin
               send_byte(8'hE0);
               if ($urandom_range(0, 1) != 0) send_byte(8'hF0);
               send_byte(ext_code[$urandom_range(0, 5)]);
            end
            default: send_byte(byte'($urandom_range(0, 255)));
         endcase
         if (exp_q.size() >= 6) drain();
      end
      drain();
      chk("random_overflow", fifo_overflow, m_ovf);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
